// File: rtl/beam_scaler_pkg.sv
// Shared types and default widths for the dual-beam trigger scaler.
// Used by dual_beam_trig_scaler and beam_holdoff_gate.
package beam_scaler_pkg;

  localparam int unsigned DEF_COUNT_WIDTH   = 24;
  localparam int unsigned DEF_PERIOD_WIDTH  = 32;
  localparam int unsigned DEF_HOLDOFF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } scaler_state_t;

  // One latched rate report at the default scaler width.
  typedef struct packed {
    logic [DEF_COUNT_WIDTH-1:0] count0;
    logic [DEF_COUNT_WIDTH-1:0] count1;
    logic [1:0]                 overflow;
    logic                       missed;
  } scaler_report_t;

endpackage

// File: rtl/beam_holdoff_gate.sv
// Per-beam trigger holdoff: accepts a trigger only after the dead time has expired.
// Holdoff counter present only when DUAL_BEAM_SCALER_HOLDOFF_EN is defined.
module beam_holdoff_gate
  import beam_scaler_pkg::*;
#(
  parameter int unsigned HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trig_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  output logic                     accept_o
);

`ifdef DUAL_BEAM_SCALER_HOLDOFF_EN
  logic [HOLDOFF_WIDTH-1:0] ho_q, ho_d;

  always_comb begin
    accept_o = trig_i && (ho_q == '0);
    ho_d     = ho_q;
    if (accept_o) begin
      ho_d = holdoff_i;
    end else if (ho_q != '0) begin
      ho_d = ho_q - HOLDOFF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ho_q <= '0;
    end else begin
      ho_q <= ho_d;
    end
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^{clk_i, rst_ni, holdoff_i};
  assign accept_o       = trig_i;
`endif

endmodule

// File: rtl/dual_beam_trig_scaler.sv
// Dual-beam trigger gate and rate scaler with valid/ack report handoff.
// Holdoff gating enabled by defining DUAL_BEAM_SCALER_HOLDOFF_EN.
module dual_beam_trig_scaler
  import beam_scaler_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH   = DEF_COUNT_WIDTH,
  parameter int unsigned PERIOD_WIDTH  = DEF_PERIOD_WIDTH,
  parameter int unsigned HOLDOFF_WIDTH = DEF_HOLDOFF_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [1:0]               trig_i,
  input  logic                     enable_i,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff_i,
  input  logic [PERIOD_WIDTH-1:0]  period_i,
  output logic [1:0]               trig_o,
  output logic [COUNT_WIDTH-1:0]   count0_o,
  output logic [COUNT_WIDTH-1:0]   count1_o,
  output logic [1:0]               overflow_o,
  output logic                     missed_o,
  output logic                     count_valid_o,
  input  logic                     count_ack_i
);

  typedef struct packed {
    logic [COUNT_WIDTH-1:0] count0;
    logic [COUNT_WIDTH-1:0] count1;
    logic [1:0]             overflow;
    logic                   missed;
  } report_t;

  logic [1:0]                  accept;
  logic [1:0]                  trig_q;
  scaler_state_t               state_q;
  logic [PERIOD_WIDTH-1:0]     cnt_q, last_q, last_d;
  logic [1:0][COUNT_WIDTH-1:0] sc_q, sc_d;
  logic [1:0]                  ovf_q, ovf_d;
  logic                        miss_q;
  logic                        valid_q;
  report_t                     rep_q;

  beam_holdoff_gate #(.HOLDOFF_WIDTH(HOLDOFF_WIDTH)) u_gate_a (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .trig_i   (trig_i[0]),
    .holdoff_i(holdoff_i),
    .accept_o (accept[0])
  );

  beam_holdoff_gate #(.HOLDOFF_WIDTH(HOLDOFF_WIDTH)) u_gate_b (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .trig_i   (trig_i[1]),
    .holdoff_i(holdoff_i),
    .accept_o (accept[1])
  );

  // Terminal count is P-1, with a period of 0 behaving as 1.
  always_comb begin
    last_d = (period_i == '0) ? '0 : period_i - PERIOD_WIDTH'(1);
    for (int unsigned b = 0; b < 2; b++) begin
      sc_d[b]  = sc_q[b];
      ovf_d[b] = ovf_q[b];
      if (accept[b]) begin
        if (sc_q[b] == '1) begin
          ovf_d[b] = 1'b1;
        end else begin
          sc_d[b] = sc_q[b] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      sc_q    <= '0;
      ovf_q   <= '0;
      miss_q  <= 1'b0;
      valid_q <= 1'b0;
      rep_q   <= '0;
    end else begin
      trig_q <= accept;
      // A transfer below overrides this ack-driven clear.
      if (valid_q && count_ack_i) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          sc_q  <= '0;
          ovf_q <= '0;
          if (enable_i) begin
            state_q <= COUNT;
            last_q  <= last_d;
          end
        end
        COUNT: begin
          if (!enable_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sc_q    <= '0;
            ovf_q   <= '0;
          end else if (cnt_q == last_q) begin
            cnt_q  <= '0;
            last_q <= last_d;
            sc_q   <= '0;
            ovf_q  <= '0;
            if (!valid_q || count_ack_i) begin
              rep_q   <= '{count0: sc_d[0], count1: sc_d[1], overflow: ovf_d, missed: miss_q};
              valid_q <= 1'b1;
              miss_q  <= 1'b0;
            end else begin
              miss_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + PERIOD_WIDTH'(1);
            sc_q  <= sc_d;
            ovf_q <= ovf_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trig_o        = trig_q;
  assign count0_o      = rep_q.count0;
  assign count1_o      = rep_q.count1;
  assign overflow_o    = rep_q.overflow;
  assign missed_o      = rep_q.missed;
  assign count_valid_o = valid_q;

endmodule

// File: tb/tb_dual_beam_trig_scaler.sv
// Self-checking bench for dual_beam_trig_scaler: directed scenarios plus random
// traffic against a cycle-level reference model (honours DUAL_BEAM_SCALER_HOLDOFF_EN).
module tb_dual_beam_trig_scaler;

  localparam int unsigned CW   = 4;
  localparam int unsigned PW   = 32;
  localparam int unsigned HW   = 8;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    trig;
  logic          en;
  logic [HW-1:0] holdoff;
  logic [PW-1:0] period;
  logic          ack;
  logic [1:0]    trig_o;
  logic [CW-1:0] count0_o, count1_o;
  logic [1:0]    overflow_o;
  logic          missed_o, valid_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int   cyc;
  bit   has_last[2];
  int   last_acc[2];
  int   hold_at[2];
  bit   running;
  int   k, per;
  int   n[2];
  bit   miss_sticky;
  logic [1:0] e_trig;
  bit   e_valid, e_miss;
  int   e_c0, e_c1;
  logic [1:0] e_ovf;

  always #5 clk = ~clk;

  dual_beam_trig_scaler #(
    .COUNT_WIDTH  (CW),
    .PERIOD_WIDTH (PW),
    .HOLDOFF_WIDTH(HW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .trig_i       (trig),
    .enable_i     (en),
    .holdoff_i    (holdoff),
    .period_i     (period),
    .trig_o       (trig_o),
    .count0_o     (count0_o),
    .count1_o     (count1_o),
    .overflow_o   (overflow_o),
    .missed_o     (missed_o),
    .count_valid_o(valid_o),
    .count_ack_i  (ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    check("trig_o",     32'(trig_o),     32'(e_trig));
    check("valid",      32'(valid_o),    32'(e_valid));
    check("count0",     32'(count0_o),   32'(e_c0));
    check("count1",     32'(count1_o),   32'(e_c1));
    check("overflow",   32'(overflow_o), 32'(e_ovf));
    check("missed",     32'(missed_o),   32'(e_miss));
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      has_last[b] = 0; last_acc[b] = 0; hold_at[b] = 0; n[b] = 0;
    end
    running = 0; k = 0; per = 1; miss_sticky = 0;
    e_trig = '0; e_valid = 0; e_miss = 0; e_c0 = 0; e_c1 = 0; e_ovf = '0;
  endtask

  function automatic int clamp(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Advance one clock with the currently driven inputs, then check outputs.
  task automatic step();
    logic [1:0] acc;
    bit v0, xfer;
    for (int b = 0; b < 2; b++) begin
`ifdef DUAL_BEAM_SCALER_HOLDOFF_EN
      acc[b] = trig[b] && (!has_last[b] || (cyc - last_acc[b]) > hold_at[b]);
`else
      acc[b] = trig[b];
`endif
      if (acc[b]) begin
        has_last[b] = 1; last_acc[b] = cyc; hold_at[b] = int'(holdoff);
      end
    end
    v0 = e_valid; xfer = 0;
    if (!running) begin
      if (en) begin
        running = 1; k = 0; per = (period == 0) ? 1 : int'(period); n[0] = 0; n[1] = 0;
      end
    end else if (!en) begin
      running = 0;
    end else begin
      n[0] += int'(acc[0]); n[1] += int'(acc[1]);
      if (k == per - 1) begin
        if (!v0 || ack) begin
          xfer = 1; e_valid = 1;
          e_c0 = clamp(n[0]); e_c1 = clamp(n[1]);
          e_ovf = {n[1] > MAXC, n[0] > MAXC};
          e_miss = miss_sticky; miss_sticky = 0;
        end else begin
          miss_sticky = 1;
        end
        k = 0; per = (period == 0) ? 1 : int'(period); n[0] = 0; n[1] = 0;
      end else begin
        k++;
      end
    end
    if (!xfer && v0 && ack) e_valid = 0;
    e_trig = acc;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic rstep(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      trig = trig ^ {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; trig = '0; en = 1'b0; holdoff = '0; period = 32'd1; ack = 1'b0;
    cyc = 0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Holdoff of 3 on a 10-cycle high level
    holdoff = 8'd3; trig = 2'b01;
    repeat (10) step();
    trig = '0;
    repeat (4) step();

    // Counting: 7 beam-A pulses in a 100-cycle period, ack held high
    period = 32'd100; ack = 1'b1; en = 1'b1;
    step();
    for (int i = 1; i <= 100; i++) begin
      trig = ((i % 10) == 5 && i <= 65) ? 2'b01 : 2'b00;
      if (i == 100) check("valid_before_e101", 32'(valid_o), 32'd0);
      step();
    end
    check("valid_e101", 32'(valid_o), 32'd1);
    check("count0_7", 32'(count0_o), 32'd7);
    check("count1_0", 32'(count1_o), 32'd0);
    check("ovf_0", 32'(overflow_o), 32'd0);

    // Saturation: beam B high 20 cycles of a 32-cycle period
    en = 1'b0; trig = '0;
    step();
    holdoff = 8'd0; period = 32'd32; en = 1'b1;
    step();
    for (int i = 1; i <= 32; i++) begin
      trig = (i <= 20) ? 2'b10 : 2'b00;
      step();
    end
    check("sat_count1", 32'(count1_o), 32'd15);
    check("sat_ovf", 32'(overflow_o), 32'd2);
    check("sat_count0", 32'(count0_o), 32'd0);

    // Backpressure: period 10, no ack for 25 cycles
    en = 1'b0;
    step();
    step();
    ack = 1'b0; holdoff = 8'd2; period = 32'd10; en = 1'b1;
    step();
    rstep(25);
    check("bp_held_valid", 32'(valid_o), 32'd1);
    check("bp_held_missed", 32'(missed_o), 32'd0);
    ack = 1'b1; rstep(1); ack = 1'b0;
    rstep(4);
    check("bp_missed_set", 32'(missed_o), 32'd1);
    ack = 1'b1; rstep(1); ack = 1'b0;
    rstep(9);
    check("bp_missed_clr", 32'(missed_o), 32'd0);

    // Ack exactly in a terminal cycle
    rstep(9);
    ack = 1'b1; rstep(1); ack = 1'b0;
    check("collision_valid", 32'(valid_o), 32'd1);

    // Abort by enable drop mid-period, then re-enable
    en = 1'b0; ack = 1'b1;
    step(); step();
    ack = 1'b0; period = 32'd100; en = 1'b1;
    step();
    rstep(49);
    en = 1'b0;
    rstep(3);
    check("abort_no_report", 32'(valid_o), 32'd0);
    period = 32'd20; en = 1'b1;
    rstep(30);

    // Abort by reset mid-period
    ack = 1'b1; rstep(2); ack = 1'b0;
    rstep(8);
    do_reset();
    rstep(25);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) en = ~en;
      ack = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 49) == 0) holdoff = HW'($urandom_range(0, 4));
      if ($urandom_range(0, 29) == 0) period = PW'($urandom_range(0, 12));
      if ($urandom_range(0, 999) == 0) do_reset();
      rstep(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_beam_trig_scaler.md
# dual_beam_trig_scaler

Downstream consumer of the dual beam threshold DSP stage. Takes the two per-beam trigger bits (SIMD sign bits, which can stay high for many cycles), applies a programmable per-beam holdoff, and emits single-cycle gated trigger pulses. It also counts the accepted triggers over a programmable period and hands the latched per-beam rates to the threshold servo/readout through a valid/ack handshake.

## Interface
Parameters:
- COUNT_WIDTH, 24, width of each per-beam scaler
- PERIOD_WIDTH, 32, width of the period counter and `period_i`
- HOLDOFF_WIDTH, 8, width of `holdoff_i`

Ports:
- clk_i  in  1  single clock; all logic is on its rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- trig_i  in  2  raw trigger bits; [0] is beam A, [1] is beam B
- enable_i  in  1  run the scaler; low means idle and clear
- holdoff_i  in  HOLDOFF_WIDTH  dead cycles after each accepted trigger; common to both beams
- period_i  in  PERIOD_WIDTH  counting period in cycles
- trig_o  out  2  gated single-cycle trigger pulses, registered
- count0_o, count1_o  out  COUNT_WIDTH  latched counts for beam A and beam B
- overflow_o  out  2  per-beam saturation flag, latched with the counts
- missed_o  out  1  at least one report was discarded since the last transfer
- count_valid_o  out  1  the latched report is valid
- count_ack_i  in  1  consumer accepts the report

## Operation
- **Gating, per beam:**
  - Holdoff counter `ho[b]`, reset 0.
  - If `trig_i[b]` and `ho[b]==0`, the trigger is accepted and `ho[b]` is loaded with `holdoff_i`.
  - Otherwise, if `ho[b]!=0`, then `ho[b]` decrements.
  - With `holdoff_i=0`, every high cycle is accepted.
  - Gating runs regardless of `enable_i`.
- **FSM IDLE/COUNT**, reset state IDLE:
  - IDLE: period counter and scalers are held at 0. IDLE goes to COUNT on `enable_i=1`.
  - COUNT goes to IDLE on `enable_i=0`. The partial period is discarded and no report is made.
- **COUNT:**
  - The period counter runs 0…P−1, where P is `period_i` sampled on entry and at each wrap. P=0 is treated as 1.
  - Each accepted trigger increments its scaler. The scaler saturates at all-ones and sets the internal overflow bit.
- **Terminal cycle** (counter = P−1):
  - Counts for the ending period include a trigger accepted in that same cycle.
  - Scalers and overflow bits clear for the next period.
  - If `count_valid_o=0`, or if `count_ack_i=1` in this cycle: transfer scalers, overflow bits and the sticky miss bit to the outputs, set `count_valid_o`, and clear the sticky miss bit.
  - Otherwise the report is discarded and the sticky miss bit is set.
- **Handshake:**
  - `count_valid_o` stays high until `count_ack_i` is sampled high.
  - `count_ack_i` while valid is low is ignored.
  - Simultaneous ack and transfer: the transfer wins and valid stays 1 with the new data.
  - Outputs are stable while valid is high.
- **Reset values:** all outputs 0 and all counters 0. Reset mid-period aborts with no report.

## Timing
- `trig_o[b]` is high in cycle n+1 for a trigger accepted in cycle n.
- Between accepted triggers of one beam there are at least `holdoff_i` idle cycles: pulse spacing ≥ `holdoff_i`+1.
- Terminal cycle t → `count_valid_o`, counts and `missed_o` update in cycle t+1.
- First report: `enable_i` rises in cycle e; the FSM enters COUNT at e+1, the terminal cycle is e+P, and valid rises at e+P+1.
- A change to `holdoff_i` takes effect on the next load of `ho`.
- A change to `period_i` takes effect at the next wrap.

## Configuration
- `DUAL_BEAM_SCALER_HOLDOFF_EN` defined: holdoff logic as described above.
- `DUAL_BEAM_SCALER_HOLDOFF_EN` undefined: holdoff counters are not built and `holdoff_i` is ignored. Every cycle with `trig_i[b]` high is accepted, so `trig_o = trig_i` delayed by one cycle and the scalers count high cycles.

## Structure
- Shared package `beam_scaler_pkg` holds:
  - the `scaler_state_t` enum (IDLE, COUNT);
  - default width constants;
  - a `scaler_report_t` struct (the two counts, overflow, missed).
- One sub-module, `beam_holdoff_gate`, instantiated twice. It takes trig, holdoff and rst_ni and produces the accept pulse.

## Test plan
- Holdoff: `holdoff_i=3`, `trig_i[0]` held high for 10 cycles → `trig_o[0]` pulses in relative cycles 1, 5 and 9. With the macro undefined → 10 consecutive pulses.
- Counting: `period_i=100`, beam A accepted 7 times, beam B 0 times, ack immediately → `count0_o=7`, `count1_o=0`, `overflow_o=0`, valid at e+101.
- Saturation: COUNT_WIDTH=4, `holdoff_i=0`, `trig_i[1]` high for 20 cycles of a 32-cycle period → `count1_o=15`, `overflow_o[1]=1`.
- Backpressure: `period_i=10`, no ack for 25 cycles, then ack → first report held, second report discarded. The next transfer carries `missed_o=1`, and the one after carries 0.
- Ack/transfer collision: ack asserted exactly in a terminal cycle → valid stays 1 and the outputs show the new counts.
- Abort: `enable_i` dropped at cycle 50 of 100, or `rst_ni` pulsed mid-period → no report. After re-enable, the counts reflect only the new period.
